// File: rtl/cv32e40p_tmr_fault_manager.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_tmr_fault_manager
// Purpose  : Watches the per-sample result flags of a TMR majority voter.
//            A replica that disagrees with the voted value for THRESH
//            consecutive valid samples gets a resync request. The request
//            uses a req/ack handshake and is followed by a cooldown window.
//            An uncorrectable sample latches a sticky fatal state that only
//            reset can clear.
// Ports    : clk_i, rst_i (sync, active-high)
//            valid_i, err_rep_i[2:0], uncorr_i : voter result for this cycle
//            resync_req_o, resync_id_o[1:0]    : resync request towards core
//            resync_ack_i                      : resync accepted/done
//            fatal_o, busy_o                   : status flags
//            corr_cnt_o, resync_cnt_o          : saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_tmr_fault_manager #(
  parameter int CNT_W    = 16,
  parameter int THRESH   = 4,
  parameter int COOLDOWN = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       err_rep_i,
  input  logic             uncorr_i,
  output logic             resync_req_o,
  output logic [1:0]       resync_id_o,
  input  logic             resync_ack_i,
  output logic             fatal_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] resync_cnt_o
);

  localparam int STRK_W = $clog2(THRESH + 1);
  localparam int CD_W   = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [STRK_W-1:0] THRESH_V  = STRK_W'(THRESH);
  localparam logic [CD_W-1:0]   CD_LOAD_V = CD_W'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_FATAL    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [STRK_W-1:0] streak     [3];
  logic [STRK_W-1:0] streak_nxt [3];
  logic [CD_W-1:0]   cd_cnt, cd_cnt_nxt;
  logic              req_nxt;
  logic [1:0]        id_nxt;
  logic              corr_inc, resync_inc;

  // Sample classification
  logic [1:0] err_pop;
  logic       single, uncorr_evt;

  assign err_pop    = {1'b0, err_rep_i[0]} + {1'b0, err_rep_i[1]} + {1'b0, err_rep_i[2]};
  assign single     = valid_i & ~uncorr_i & (err_pop == 2'd1);
  assign uncorr_evt = valid_i & (uncorr_i | (err_pop >= 2'd2));

  // Streak update as it would happen in IDLE, plus which replica (if any)
  // reaches the threshold on this sample.
  logic [STRK_W-1:0] streak_upd [3];
  logic              hit;
  logic [1:0]        hit_id;

  always_comb begin
    hit    = 1'b0;
    hit_id = 2'd0;
    for (int k = 0; k < 3; k++) begin
      streak_upd[k] = '0;
      if (err_rep_i[k]) begin
        streak_upd[k] = (streak[k] == THRESH_V) ? streak[k] : streak[k] + 1'b1;
        if (single && (streak_upd[k] == THRESH_V)) begin
          hit    = 1'b1;
          hit_id = 2'(k);
        end
      end
    end
  end

  // Next-state / next-output logic. Outputs are registered from these values,
  // so fatal/busy/req reflect the state entered at the same edge.
  always_comb begin
    state_nxt  = state;
    req_nxt    = resync_req_o;
    id_nxt     = resync_id_o;
    cd_cnt_nxt = cd_cnt;
    resync_inc = 1'b0;
    corr_inc   = single & (state != ST_FATAL);
    for (int k = 0; k < 3; k++) streak_nxt[k] = streak[k];

    case (state)
      ST_IDLE: begin
        if (uncorr_evt) begin
          state_nxt = ST_FATAL;
          req_nxt   = 1'b0;
          id_nxt    = 2'd0;
        end else if (valid_i) begin
          for (int k = 0; k < 3; k++) streak_nxt[k] = streak_upd[k];
          if (hit) begin
            state_nxt = ST_REQ;
            req_nxt   = 1'b1;
            id_nxt    = hit_id;
          end
        end
      end
      ST_REQ: begin
        if (uncorr_evt) begin
          state_nxt = ST_FATAL;
          req_nxt   = 1'b0;
          id_nxt    = 2'd0;
        end else if (resync_ack_i) begin
          state_nxt  = ST_COOLDOWN;
          req_nxt    = 1'b0;
          id_nxt     = 2'd0;
          resync_inc = 1'b1;
          cd_cnt_nxt = CD_LOAD_V;
          for (int k = 0; k < 3; k++) streak_nxt[k] = '0;
        end
      end
      ST_COOLDOWN: begin
        // Counter is loaded with COOLDOWN-1 so exactly COOLDOWN cycles are
        // spent here before returning to IDLE.
        if (uncorr_evt) begin
          state_nxt = ST_FATAL;
        end else if (cd_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cd_cnt_nxt = cd_cnt - 1'b1;
        end
      end
      default: begin
        // FATAL: everything frozen until reset.
        state_nxt = ST_FATAL;
        req_nxt   = 1'b0;
        id_nxt    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cd_cnt       <= '0;
      resync_req_o <= 1'b0;
      resync_id_o  <= 2'd0;
      fatal_o      <= 1'b0;
      busy_o       <= 1'b0;
      corr_cnt_o   <= '0;
      resync_cnt_o <= '0;
      for (int k = 0; k < 3; k++) streak[k] <= '0;
    end else begin
      state        <= state_nxt;
      cd_cnt       <= cd_cnt_nxt;
      resync_req_o <= req_nxt;
      resync_id_o  <= id_nxt;
      fatal_o      <= (state_nxt == ST_FATAL);
      busy_o       <= (state_nxt != ST_IDLE);
      for (int k = 0; k < 3; k++) streak[k] <= streak_nxt[k];
      if (corr_inc && (corr_cnt_o != '1))
        corr_cnt_o <= corr_cnt_o + 1'b1;
      if (resync_inc && (resync_cnt_o != '1))
        resync_cnt_o <= resync_cnt_o + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_tmr_fault_manager
// Purpose  : Self-checking bench. A driver applies one input vector per
//            cycle and pushes the reference model's expected outputs into a
//            queue; a monitor pops and compares one entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_tmr_fault_manager;

  localparam int CNT_W    = 4;
  localparam int THRESH   = 4;
  localparam int COOLDOWN = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             valid_i = 1'b0;
  logic [2:0]       err_rep_i = 3'b000;
  logic             uncorr_i = 1'b0;
  logic             resync_ack_i = 1'b0;
  logic             resync_req_o;
  logic [1:0]       resync_id_o;
  logic             fatal_o;
  logic             busy_o;
  logic [CNT_W-1:0] corr_cnt_o;
  logic [CNT_W-1:0] resync_cnt_o;

  always #5 clk_i = ~clk_i;

  cv32e40p_tmr_fault_manager #(
    .CNT_W(CNT_W), .THRESH(THRESH), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .err_rep_i(err_rep_i),
    .uncorr_i(uncorr_i), .resync_req_o(resync_req_o), .resync_id_o(resync_id_o),
    .resync_ack_i(resync_ack_i), .fatal_o(fatal_o), .busy_o(busy_o),
    .corr_cnt_o(corr_cnt_o), .resync_cnt_o(resync_cnt_o)
  );

  typedef struct packed {
    logic             req;
    logic [1:0]       id;
    logic             fatal;
    logic             busy;
    logic [CNT_W-1:0] corr;
    logic [CNT_W-1:0] rcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // ---------------- reference model (rule-level) ----------------
  bit m_fatal, m_req;
  int m_id, m_cool, m_corr, m_rcnt;
  int m_streak[3];

  task automatic model(input bit r, input bit v, input bit [2:0] e, input bit u, input bit a);
    int  pc;
    bit  single, bad;
    if (r) begin
      m_fatal = 0; m_req = 0; m_id = 0; m_cool = 0; m_corr = 0; m_rcnt = 0;
      for (int k = 0; k < 3; k++) m_streak[k] = 0;
      return;
    end
    if (m_fatal) return;
    pc     = $countones(e);
    single = v && !u && (pc == 1);
    bad    = v && (u || pc >= 2);
    if (bad) begin
      m_fatal = 1; m_req = 0; m_id = 0; m_cool = 0;
      return;
    end
    if (single && m_corr < CNT_MAX) m_corr++;
    if (m_req) begin
      if (a) begin
        m_req = 0; m_id = 0; m_cool = COOLDOWN;
        if (m_rcnt < CNT_MAX) m_rcnt++;
        for (int k = 0; k < 3; k++) m_streak[k] = 0;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (v) begin
      for (int k = 0; k < 3; k++)
        m_streak[k] = e[k] ? ((m_streak[k] < THRESH) ? m_streak[k] + 1 : THRESH) : 0;
      for (int k = 0; k < 3; k++)
        if (single && e[k] && m_streak[k] == THRESH) begin
          m_req = 1; m_id = k;
        end
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.req   = m_req;
    x.id    = 2'(m_id);
    x.fatal = m_fatal;
    x.busy  = m_fatal || m_req || (m_cool > 0);
    x.corr  = CNT_W'(m_corr);
    x.rcnt  = CNT_W'(m_rcnt);
    return x;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit v, input bit [2:0] e, input bit u, input bit a);
    rst_i = r; valid_i = v; err_rep_i = e; uncorr_i = u; resync_ack_i = a;
    @(posedge clk_i);
    model(r, v, e, u, a);
    exp_q.push_back(model_out());
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'b000, 0, 0);
  endtask

  task automatic single_s(input bit [2:0] e);
    step(0, 1, e, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 3'b000, 0, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t x, got;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        got = '{resync_req_o, resync_id_o, fatal_o, busy_o, corr_cnt_o, resync_cnt_o};
        checks++;
        if (got !== x) begin
          errors++;
          $display("FAIL out_check cyc=%0d: got req=%0b id=%0d fatal=%0b busy=%0b corr=%0d rcnt=%0d, expected req=%0b id=%0d fatal=%0b busy=%0b corr=%0d rcnt=%0d",
                   cyc, got.req, got.id, got.fatal, got.busy, got.corr, got.rcnt,
                   x.req, x.id, x.fatal, x.busy, x.corr, x.rcnt);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int fav;
    @(negedge clk_i);

    // 1. reset with random inputs, then release
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    idle(2);

    // 2. threshold resync on replica 1, ack on 3rd REQ cycle, cooldown
    for (int i = 0; i < 4; i++) single_s(3'b010);
    idle(2);
    step(0, 0, 3'b000, 0, 1);
    idle(COOLDOWN + 3);

    // 3. streak break, then valid_i=0 gaps inside a streak
    do_reset();
    single_s(3'b010); single_s(3'b010); single_s(3'b010);
    step(0, 1, 3'b000, 0, 0);
    single_s(3'b010); single_s(3'b010); single_s(3'b010);
    idle(1);
    do_reset();
    single_s(3'b001); idle(1); single_s(3'b001); idle(2);
    single_s(3'b001); single_s(3'b001);
    idle(1);
    step(0, 0, 3'b000, 0, 1);
    idle(COOLDOWN + 1);

    // 4. fatal during handshake; later ack and samples ignored
    do_reset();
    for (int i = 0; i < 4; i++) single_s(3'b100);
    idle(1);
    step(0, 1, 3'b000, 1, 0);
    step(0, 0, 3'b000, 0, 1);
    single_s(3'b001); single_s(3'b010);
    step(0, 1, 3'b100, 0, 1);
    idle(2);

    // 5. illegal two-bit pattern; threshold sample with uncorr in same cycle
    do_reset();
    step(0, 1, 3'b011, 0, 0);
    idle(2);
    do_reset();
    for (int i = 0; i < 3; i++) single_s(3'b001);
    step(0, 1, 3'b001, 1, 0);
    idle(2);

    // 6. counter saturation without resync
    do_reset();
    for (int i = 0; i < 20; i++) single_s((i % 2 == 0) ? 3'b001 : 3'b100);
    idle(2);

    // Randomised traffic
    do_reset();
    fav = 0;
    for (int i = 0; i < 3000; i++) begin
      int  r;
      bit  v, u, a;
      bit [2:0] e;
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 99) < 85);
      a = ($urandom_range(0, 99) < 30);
      u = 0;
      if ($urandom_range(0, 49) == 0) fav = $urandom_range(0, 2);
      if (r < 35)      e = 3'b000;
      else if (r < 85) e = 3'(1 << fav);
      else if (r < 97) e = 3'(1 << $urandom_range(0, 2));
      else if (r < 99) e = 3'($urandom);
      else begin e = 3'($urandom); u = 1; end
      if (m_fatal && $urandom_range(0, 9) == 0) step(1, v, e, u, a);
      else                                      step(0, v, e, u, a);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
